// File: rtl/mem_arbiter_ctrl.sv
// mem_arbiter_ctrl
//   Shares one byte-wide RAM/IO port between the instruction fetcher (IF) and
//   the load/store buffer (LSB). It breaks each 1/2/4-byte request into
//   single-byte cycles and reassembles read data little-endian. A one-cycle
//   done pulse goes to the requester that was served. The two requesters are
//   arbitrated round-robin, and speculative reads are dropped on ROB roll back.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global ready; low freezes every register
//   mem_din/mem_dout    RAM/IO read byte / write byte
//   mem_a, mem_wr       RAM/IO byte address, write strobe
//   io_buffer_full      IO write buffer full (stalls stores to IO space)
//   IF_*                fetch request (4 bytes) and done/instruction result
//   LSB_*               load/store request and done/load-data result
//   ROB_roll_back       flush speculative reads
//   state_dbg           current FSM state (IDLE=0, IF_RD=1, LSB_RD=2, LSB_WR=3)
//
// Handshake: a requester raises *_req_valid and holds it (with stable
// payload) until it sees its *_done pulse. It then drops valid. The pulse
// lasts exactly one cycle. The controller accepts nothing on the cycle after
// any done pulse.
module mem_arbiter_ctrl #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter logic [1:0]  IO_ADDR_HI = 2'b11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full,
  input  logic                  IF_req_valid,
  input  logic [ADDR_WIDTH-1:0] IF_req_addr,
  output logic                  IF_done,
  output logic [DATA_WIDTH-1:0] IF_inst,
  input  logic                  LSB_req_valid,
  input  logic                  LSB_req_wr,
  input  logic [ADDR_WIDTH-1:0] LSB_req_addr,
  input  logic [1:0]            LSB_req_size,
  input  logic [DATA_WIDTH-1:0] LSB_req_data,
  output logic                  LSB_done,
  output logic [DATA_WIDTH-1:0] LSB_rdata,
  input  logic                  ROB_roll_back,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, IF_RD = 2'd1, LSB_RD = 2'd2, LSB_WR = 2'd3} state_t;

  state_t                state;
  logic                  last_grant;   // 0 = IF, 1 = LSB
  logic [2:0]            step;         // bytes issued (write) / edges since accept (read)
  logic [2:0]            nbytes;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rbuf;

  logic                  can_accept;
  logic                  grant_lsb;
  logic                  acc_blocked;
  logic                  wr_blocked;
  logic [2:0]            req_nbytes;
  logic [2:0]            cap_idx;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] rd_merge;
  logic [7:0]            wr_byte;

  assign state_dbg  = state;
  assign can_accept = !IF_done && !LSB_done && !ROB_roll_back;
  // With both requesting, the one not served last time wins.
  assign grant_lsb  = LSB_req_valid && (!IF_req_valid || !last_grant);
  assign req_nbytes = (LSB_req_size == 2'd0) ? 3'd1 :
                      (LSB_req_size == 2'd1) ? 3'd2 : 3'd4;
  assign cur_addr   = base_addr + ADDR_WIDTH'(step);
  assign acc_blocked = (LSB_req_addr[17:16] == IO_ADDR_HI) && io_buffer_full;
  assign wr_blocked  = (cur_addr[17:16] == IO_ADDR_HI) && io_buffer_full;

  // Byte arriving on mem_din belongs to the address driven two edges ago.
  always_comb begin
    cap_idx  = step - 3'd2;
    rd_merge = rbuf;
    for (int i = 0; i < 4; i++)
      if (cap_idx[1:0] == 2'(i)) rd_merge[8*i +: 8] = mem_din;
    wr_byte = wdata[7:0];
    for (int i = 0; i < 4; i++)
      if (step[1:0] == 2'(i)) wr_byte = wdata[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      step       <= 3'd0;
      nbytes     <= 3'd0;
      base_addr  <= '0;
      wdata      <= '0;
      rbuf       <= '0;
      mem_a      <= '0;
      mem_dout   <= 8'h00;
      mem_wr     <= 1'b0;
      IF_done    <= 1'b0;
      LSB_done   <= 1'b0;
      IF_inst    <= '0;
      LSB_rdata  <= '0;
    end else if (rdy) begin
      IF_done  <= 1'b0;
      LSB_done <= 1'b0;
      mem_wr   <= 1'b0;
      case (state)
        IDLE: begin
          if (can_accept && (IF_req_valid || LSB_req_valid)) begin
            step <= 3'd1;
            rbuf <= '0;
            if (grant_lsb) begin
              last_grant <= 1'b1;
              base_addr  <= LSB_req_addr;
              nbytes     <= req_nbytes;
              wdata      <= LSB_req_data;
              mem_a      <= LSB_req_addr;
              if (LSB_req_wr) begin
                state <= LSB_WR;
                // Byte 0 goes out on the accept edge unless IO is full.
                if (acc_blocked) begin
                  step <= 3'd0;
                end else begin
                  mem_wr   <= 1'b1;
                  mem_dout <= LSB_req_data[7:0];
                end
              end else begin
                state <= LSB_RD;
              end
            end else begin
              last_grant <= 1'b0;
              base_addr  <= IF_req_addr;
              nbytes     <= 3'd4;
              mem_a      <= IF_req_addr;
              state      <= IF_RD;
            end
          end
        end
        IF_RD, LSB_RD: begin
          if (ROB_roll_back) begin
            state <= IDLE;
          end else begin
            if (step < nbytes) mem_a <= cur_addr;
            if (step >= 3'd2) rbuf <= rd_merge;
            step <= step + 3'd1;
            if (step == nbytes + 3'd1) begin
              state <= IDLE;
              if (state == IF_RD) begin
                IF_inst <= rd_merge;
                IF_done <= 1'b1;
              end else begin
                LSB_rdata <= rd_merge;
                LSB_done  <= 1'b1;
              end
            end
          end
        end
        LSB_WR: begin
          // Committed store: roll back does not interrupt it.
          if (step < nbytes) begin
            if (!wr_blocked) begin
              mem_a    <= cur_addr;
              mem_dout <= wr_byte;
              mem_wr   <= 1'b1;
              step     <= step + 3'd1;
            end
          end else begin
            LSB_done <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Directed bench for mem_arbiter_ctrl with a two-edge-latency byte RAM model.
module tb_mem_arbiter_ctrl;
  logic        clk = 1'b0;
  logic        rst, rdy;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;
  logic        IF_req_valid, IF_done;
  logic [31:0] IF_req_addr, IF_inst;
  logic        LSB_req_valid, LSB_req_wr, LSB_done;
  logic [31:0] LSB_req_addr, LSB_req_data, LSB_rdata;
  logic [1:0]  LSB_req_size, state_dbg;
  logic        ROB_roll_back;

  int n_checks = 0;
  int n_pass   = 0;
  logic [39:0] exp_q[$];   // {addr, byte} of expected writes
  logic [7:0]  ram [0:4095];

  mem_arbiter_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full),
    .IF_req_valid(IF_req_valid), .IF_req_addr(IF_req_addr), .IF_done(IF_done),
    .IF_inst(IF_inst), .LSB_req_valid(LSB_req_valid), .LSB_req_wr(LSB_req_wr),
    .LSB_req_addr(LSB_req_addr), .LSB_req_size(LSB_req_size),
    .LSB_req_data(LSB_req_data), .LSB_done(LSB_done), .LSB_rdata(LSB_rdata),
    .ROB_roll_back(ROB_roll_back), .state_dbg(state_dbg)
  );

  // clock / RAM model
  always #5 clk = ~clk;
  always @(posedge clk) if (rdy) mem_din <= ram[mem_a[11:0]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Ticks until the selected done pulses; returns edge count, 0 on timeout.
  task automatic wait_done(input bit sel_lsb, output int edges);
    edges = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if ((sel_lsb ? LSB_done : IF_done) === 1'b1) begin
        edges = i;
        break;
      end
    end
  endtask

  // Ticks through a store, checking each write against exp_q.
  task automatic run_store(input int max_ticks, output int done_tick);
    done_tick = 0;
    for (int i = 1; i <= max_ticks; i++) begin
      tick();
      if (mem_wr === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL unexpected_write addr=%h data=%h", mem_a, mem_dout);
        else begin
          logic [39:0] e;
          e = exp_q.pop_front();
          if ({mem_a, mem_dout} !== e) $display("FAIL write_byte got=%h exp=%h", {mem_a, mem_dout}, e);
          else n_pass++;
        end
      end
      if (LSB_done === 1'b1) begin
        done_tick = i;
        break;
      end
    end
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL writes_missing left=%0d exp=0", exp_q.size());
    else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_checks++; if (state_dbg !== 2'd0) $display("FAIL rst_state got=%0d exp=0", state_dbg); else n_pass++;
    n_checks++; if (mem_a !== 32'h0) $display("FAIL rst_mem_a got=%h exp=0", mem_a); else n_pass++;
    n_checks++; if ({mem_wr, mem_dout} !== 9'h0) $display("FAIL rst_wr_dout got=%h exp=0", {mem_wr, mem_dout}); else n_pass++;
    n_checks++; if ({IF_done, LSB_done} !== 2'b00) $display("FAIL rst_done got=%b exp=00", {IF_done, LSB_done}); else n_pass++;
    n_checks++; if ({IF_inst, LSB_rdata} !== 64'h0) $display("FAIL rst_data got=%h exp=0", {IF_inst, LSB_rdata}); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_if_fetch();
    int e;
    IF_req_addr  = 32'h100;
    IF_req_valid = 1'b1;
    tick();
    n_checks++; if (state_dbg !== 2'd1 || mem_a !== 32'h100) $display("FAIL if_accept state=%0d a=%h exp=1/100", state_dbg, mem_a); else n_pass++;
    wait_done(1'b0, e);
    n_checks++; if (e != 5) $display("FAIL if_latency got=%0d exp=5", e); else n_pass++;
    n_checks++; if (IF_inst !== 32'h00100513) $display("FAIL if_inst got=%h exp=00100513", IF_inst); else n_pass++;
    IF_req_valid = 1'b0;
    tick();
    n_checks++; if (IF_done !== 1'b0) $display("FAIL if_done_once got=%b exp=0", IF_done); else n_pass++;
  endtask

  task automatic test_arbitration();
    int e;
    do_reset();
    IF_req_addr   = 32'h100;
    IF_req_valid  = 1'b1;
    LSB_req_addr  = 32'h204;
    LSB_req_size  = 2'd1;
    LSB_req_wr    = 1'b0;
    LSB_req_valid = 1'b1;
    tick();
    n_checks++; if (state_dbg !== 2'd2) $display("FAIL arb_first got=%0d exp=2", state_dbg); else n_pass++;
    wait_done(1'b1, e);
    n_checks++; if (e != 3) $display("FAIL ld2_latency got=%0d exp=3", e); else n_pass++;
    n_checks++; if (LSB_rdata !== 32'h00001234) $display("FAIL ld2_data got=%h exp=00001234", LSB_rdata); else n_pass++;
    LSB_req_valid = 1'b0;
    tick();
    n_checks++; if (state_dbg !== 2'd0) $display("FAIL turnaround got=%0d exp=0", state_dbg); else n_pass++;
    tick();
    n_checks++; if (state_dbg !== 2'd1) $display("FAIL arb_second got=%0d exp=1", state_dbg); else n_pass++;
    wait_done(1'b0, e);
    n_checks++; if (e != 5 || IF_inst !== 32'h00100513) $display("FAIL arb_if got=%0d/%h exp=5/00100513", e, IF_inst); else n_pass++;
    LSB_req_valid = 1'b1;
    tick();
    tick();
    n_checks++; if (state_dbg !== 2'd2) $display("FAIL arb_alternate got=%0d exp=2", state_dbg); else n_pass++;
    wait_done(1'b1, e);
    IF_req_valid  = 1'b0;
    LSB_req_valid = 1'b0;
    tick();
  endtask

  task automatic test_load_1b();
    int e;
    LSB_req_addr  = 32'h206;
    LSB_req_size  = 2'd0;
    LSB_req_wr    = 1'b0;
    LSB_req_valid = 1'b1;
    wait_done(1'b1, e);
    n_checks++; if (e != 3) $display("FAIL ld1_latency got=%0d exp=3", e); else n_pass++;
    n_checks++; if (LSB_rdata !== 32'h00000078) $display("FAIL ld1_data got=%h exp=00000078", LSB_rdata); else n_pass++;
    LSB_req_valid = 1'b0;
    tick();
  endtask

  task automatic test_store();
    int d;
    exp_q.push_back({32'h3FF0, 8'hEF});
    exp_q.push_back({32'h3FF1, 8'hBE});
    LSB_req_addr  = 32'h3FF0;
    LSB_req_size  = 2'd1;
    LSB_req_wr    = 1'b1;
    LSB_req_data  = 32'h0000BEEF;
    LSB_req_valid = 1'b1;
    run_store(10, d);
    n_checks++; if (d != 3 || mem_wr !== 1'b0) $display("FAIL st2_done got=%0d/%b exp=3/0", d, mem_wr); else n_pass++;
    LSB_req_valid = 1'b0;
    tick();
  endtask

  task automatic test_io_store();
    int wr_seen = 0;
    LSB_req_addr   = 32'h30000;
    LSB_req_size   = 2'd0;
    LSB_req_wr     = 1'b1;
    LSB_req_data   = 32'h0000005A;
    LSB_req_valid  = 1'b1;
    io_buffer_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mem_wr !== 1'b0) wr_seen++;
    end
    n_checks++; if (wr_seen != 0) $display("FAIL io_stall got=%0d exp=0", wr_seen); else n_pass++;
    io_buffer_full = 1'b0;
    tick();
    n_checks++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h30000, 8'h5A}) $display("FAIL io_write got=%b/%h/%h exp=1/30000/5a", mem_wr, mem_a, mem_dout); else n_pass++;
    tick();
    n_checks++; if (LSB_done !== 1'b1 || mem_wr !== 1'b0) $display("FAIL io_done got=%b/%b exp=1/0", LSB_done, mem_wr); else n_pass++;
    LSB_req_valid = 1'b0;
    tick();
  endtask

  task automatic test_rollback();
    int dn = 0;
    int d;
    IF_req_addr  = 32'h100;
    IF_req_valid = 1'b1;
    tick();
    tick();
    ROB_roll_back = 1'b1;
    tick();
    n_checks++; if (state_dbg !== 2'd0) $display("FAIL rb_idle got=%0d exp=0", state_dbg); else n_pass++;
    ROB_roll_back = 1'b0;
    IF_req_valid  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (IF_done !== 1'b0) dn++;
      tick();
    end
    n_checks++; if (dn != 0) $display("FAIL rb_no_done got=%0d exp=0", dn); else n_pass++;
    // store keeps going through roll back
    exp_q.push_back({32'h1000, 8'h44});
    exp_q.push_back({32'h1001, 8'h33});
    exp_q.push_back({32'h1002, 8'h22});
    exp_q.push_back({32'h1003, 8'h11});
    LSB_req_addr  = 32'h1000;
    LSB_req_size  = 2'd2;
    LSB_req_wr    = 1'b1;
    LSB_req_data  = 32'h11223344;
    LSB_req_valid = 1'b1;
    tick();
    n_checks++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h1000, 8'h44}) $display("FAIL rb_st_first got=%b/%h/%h exp=1/1000/44", mem_wr, mem_a, mem_dout); else n_pass++;
    void'(exp_q.pop_front());
    ROB_roll_back = 1'b1;
    run_store(10, d);
    n_checks++; if (d != 4) $display("FAIL rb_st_done got=%0d exp=4", d); else n_pass++;
    ROB_roll_back = 1'b0;
    LSB_req_valid = 1'b0;
    tick();
  endtask

  task automatic test_rdy_freeze();
    int bad = 0;
    int e;
    LSB_req_addr  = 32'h204;
    LSB_req_size  = 2'd2;
    LSB_req_wr    = 1'b0;
    LSB_req_valid = 1'b1;
    tick();
    tick();
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mem_a !== 32'h205 || state_dbg !== 2'd2 || mem_wr !== 1'b0 || LSB_done !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL freeze_hold got=%0d exp=0", bad); else n_pass++;
    rdy = 1'b1;
    wait_done(1'b1, e);
    n_checks++; if (e != 4) $display("FAIL freeze_latency got=%0d exp=4", e); else n_pass++;
    n_checks++; if (LSB_rdata !== 32'h56781234) $display("FAIL freeze_data got=%h exp=56781234", LSB_rdata); else n_pass++;
    LSB_req_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    LSB_req_addr  = 32'h1000;
    LSB_req_size  = 2'd2;
    LSB_req_wr    = 1'b1;
    LSB_req_data  = 32'hCAFEF00D;
    LSB_req_valid = 1'b1;
    tick();
    rst = 1'b1;
    LSB_req_valid = 1'b0;
    tick();
    n_checks++; if ({mem_wr, mem_a, state_dbg} !== {1'b0, 32'h0, 2'd0}) $display("FAIL rst_mid got=%b/%h/%0d exp=0/0/0", mem_wr, mem_a, state_dbg); else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0; ROB_roll_back = 1'b0;
    IF_req_valid = 1'b0; IF_req_addr = '0;
    LSB_req_valid = 1'b0; LSB_req_wr = 1'b0; LSB_req_addr = '0;
    LSB_req_size = 2'd0; LSB_req_data = '0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h10; ram[12'h103] = 8'h00;
    ram[12'h204] = 8'h34; ram[12'h205] = 8'h12; ram[12'h206] = 8'h78; ram[12'h207] = 8'h56;
    test_reset();
    test_if_fetch();
    test_arbitration();
    test_load_1b();
    test_store();
    test_io_store();
    test_rollback();
    test_rdy_freeze();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached exp=finish");
    $fatal(1, "timeout");
  end
endmodule
